// File: rtl/axis_to_vector_if.sv
// Stream-in / vector-out handshake bundle for axis_to_vector.
// slave = deserialiser side, master = producer/consumer side.
interface axis_to_vector_if #(
    parameter int AXIS_BYTES = 1,
    parameter int VEC_BYTES  = 1
);
    logic                      axis_tvalid;
    logic                      axis_tready;
    logic                      axis_tlast;
    logic [AXIS_BYTES*8-1:0]   axis_tdata;
    logic [VEC_BYTES*8-1:0]    vec;
    logic                      vec_valid;
    logic                      vec_ready;
    logic                      framing_err;

    modport slave (
        input  axis_tvalid,
        input  axis_tlast,
        input  axis_tdata,
        input  vec_ready,
        output axis_tready,
        output vec,
        output vec_valid,
        output framing_err
    );

    modport master (
        output axis_tvalid,
        output axis_tlast,
        output axis_tdata,
        output vec_ready,
        input  axis_tready,
        input  vec,
        input  vec_valid,
        input  framing_err
    );
endinterface

// File: rtl/axis_to_vector.sv
// AXI-stream to wide-vector deserialiser with held valid/ready output.
// Define AXIS_TO_VECTOR_TLAST_CHECK_EN for tlast framing checks and RESYNC.
module axis_to_vector #(
    parameter int VEC_BYTES  = 1,
    parameter int AXIS_BYTES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic               clk,
    input  logic               sresetn,
    axis_to_vector_if.slave    bus
);
    localparam int BW = AXIS_BYTES * 8;
    localparam int VW = VEC_BYTES * 8;
    localparam int N  = VEC_BYTES / AXIS_BYTES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [VW-1:0] r_asm;
    logic [VW-1:0] r_vec;
    logic          r_vec_valid;
    logic [CW-1:0] r_ctr;

    logic [VW-1:0] w_merged;
    logic [CW-1:0] w_slice;
    logic          w_at_last;
    logic          w_tready;
    logic          w_accept;
    logic          w_store;
    logic          w_complete;

    assign w_at_last = (r_ctr == LAST);
    assign w_accept  = bus.axis_tvalid && w_tready;

    // Current beat merged into the partial word at its slice position
    always_comb begin
        w_slice = (MSB_FIRST != 0) ? (LAST - r_ctr) : r_ctr;
        w_merged = r_asm;
        w_merged[int'(w_slice)*BW +: BW] = bus.axis_tdata;
    end

`ifdef AXIS_TO_VECTOR_TLAST_CHECK_EN
    typedef enum logic {
        S_COLLECT,
        S_RESYNC
    } state_t;

    state_t r_state;
    logic   r_ferr;
    logic   w_collect;
    logic   w_err_early;
    logic   w_err_miss;

    assign w_collect = (r_state == S_COLLECT);

    assign w_tready = sresetn &&
        !(w_at_last && w_collect && r_vec_valid && !bus.vec_ready);

    assign w_err_early = w_accept && w_collect &&
        bus.axis_tlast && !w_at_last;
    assign w_err_miss = w_accept && w_collect &&
        w_at_last && !bus.axis_tlast;
    assign w_store = w_accept && w_collect &&
        !bus.axis_tlast && !w_at_last;
    assign w_complete = w_accept && w_collect &&
        w_at_last && bus.axis_tlast;

    assign bus.framing_err = r_ferr;
`else
    logic w_unused_tlast;

    assign w_unused_tlast = bus.axis_tlast;

    assign w_tready = sresetn &&
        !(w_at_last && r_vec_valid && !bus.vec_ready);

    assign w_store    = w_accept && !w_at_last;
    assign w_complete = w_accept && w_at_last;

    assign bus.framing_err = 1'b0;
`endif

    assign bus.axis_tready = w_tready;
    assign bus.vec         = r_vec;
    assign bus.vec_valid   = r_vec_valid;

    // Partial word needs no reset: every slice is rewritten per word
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_asm <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_ctr       <= '0;
`ifdef AXIS_TO_VECTOR_TLAST_CHECK_EN
            r_state     <= S_COLLECT;
            r_ferr      <= 1'b0;
`endif
        end else begin
            if (w_complete) begin
                r_vec       <= w_merged;
                r_vec_valid <= 1'b1;
            end else if (r_vec_valid && bus.vec_ready) begin
                r_vec_valid <= 1'b0;
            end

            if (w_store) begin
                r_ctr <= r_ctr + CW'(1);
            end else if (w_complete) begin
                r_ctr <= '0;
            end

`ifdef AXIS_TO_VECTOR_TLAST_CHECK_EN
            r_ferr <= w_err_early || w_err_miss;

            unique case (r_state)
                S_COLLECT: begin
                    if (w_err_early || w_err_miss) begin
                        r_ctr <= '0;
                    end
                    if (w_err_miss) begin
                        r_state <= S_RESYNC;
                    end
                end
                S_RESYNC: begin
                    // ctr is already 0 here; only the tlast beat ends the drop
                    if (w_accept && bus.axis_tlast) begin
                        r_state <= S_COLLECT;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_axis_to_vector.sv
// Scoreboard bench for axis_to_vector: directed words on three instances
// (LSB-first bytes, MSB-first bytes sharing the same stream, 16-bit beats).
module tb_axis_to_vector;
    logic clk;
    logic sresetn;

    int total;
    int bad;
    int ferr_cnt;
    int ferr_exp;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    axis_to_vector_if #(.AXIS_BYTES(1), .VEC_BYTES(4)) b0 ();
    axis_to_vector_if #(.AXIS_BYTES(1), .VEC_BYTES(4)) b1 ();
    axis_to_vector_if #(.AXIS_BYTES(2), .VEC_BYTES(4)) b2 ();

    assign b1.axis_tvalid = b0.axis_tvalid;
    assign b1.axis_tlast  = b0.axis_tlast;
    assign b1.axis_tdata  = b0.axis_tdata;
    assign b1.vec_ready   = b0.vec_ready;

    axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(0)) u0 (
        .clk     (clk),
        .sresetn (sresetn),
        .bus     (b0.slave)
    );

    axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1)) u1 (
        .clk     (clk),
        .sresetn (sresetn),
        .bus     (b1.slave)
    );

    axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(2), .MSB_FIRST(0)) u2 (
        .clk     (clk),
        .sresetn (sresetn),
        .bus     (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Monitor: pops an expectation whenever an instance hands over a word
    always @(negedge clk) begin
        if (sresetn && b0.vec_valid && b0.vec_ready) begin
            if (q0.size() == 0) check("vec_lsb_extra", b0.vec, 32'hxxxxxxxx);
            else check("vec_lsb", b0.vec, q0.pop_front());
        end
        if (sresetn && b1.vec_valid && b1.vec_ready) begin
            if (q1.size() == 0) check("vec_msb_extra", b1.vec, 32'hxxxxxxxx);
            else check("vec_msb", b1.vec, q1.pop_front());
        end
        if (sresetn && b2.vec_valid && b2.vec_ready) begin
            if (q2.size() == 0) check("vec_w16_extra", b2.vec, 32'hxxxxxxxx);
            else check("vec_w16", b2.vec, q2.pop_front());
        end
        if (b0.framing_err) ferr_cnt++;
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_beat(input logic [7:0] d, input logic last);
        bit done;
        done = 1'b0;
        b0.axis_tvalid = 1'b1;
        b0.axis_tdata  = d;
        b0.axis_tlast  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (b0.axis_tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got=stalled want=accepted");
        end
        b0.axis_tvalid = 1'b0;
        b0.axis_tlast  = 1'b0;
    endtask

    task automatic send_beat2(input logic [15:0] d, input logic last);
        bit done;
        done = 1'b0;
        b2.axis_tvalid = 1'b1;
        b2.axis_tdata  = d;
        b2.axis_tlast  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (b2.axis_tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL beat2_timeout got=stalled want=accepted");
        end
        b2.axis_tvalid = 1'b0;
        b2.axis_tlast  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input logic tl,
                             input bit push);
        logic [31:0] t;
        t = v;
        if (push) begin
            q0.push_back(v);
            q1.push_back(swap(v));
        end
        for (int k = 0; k < 4; k++) begin
            send_beat(t[7:0], (k == 3) ? tl : 1'b0);
            t = t >> 8;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int f0;
        total    = 0;
        bad      = 0;
        ferr_cnt = 0;
        ferr_exp = 0;
        sresetn  = 1'b0;
        b0.axis_tvalid = 1'b0;
        b0.axis_tlast  = 1'b0;
        b0.axis_tdata  = '0;
        b0.vec_ready   = 1'b1;
        b2.axis_tvalid = 1'b0;
        b2.axis_tlast  = 1'b0;
        b2.axis_tdata  = '0;
        b2.vec_ready   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vec", b0.vec, 32'h0);
        check("rst_valid", {31'b0, b0.vec_valid}, 32'h0);
        check("rst_ferr", {31'b0, b0.framing_err}, 32'h0);
        check("rst_tready", {31'b0, b0.axis_tready}, 32'h0);
        @(posedge clk);
        #1;
        sresetn = 1'b1;

        // Basic word and one-cycle latency
        q0.push_back(32'h44332211);
        q1.push_back(32'h11223344);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        @(negedge clk);
        check("lat_valid", {31'b0, b0.vec_valid}, 32'h1);
        @(posedge clk);
        #1;

        // Back-to-back words at full rate
        send_word(32'hDEADBEEF, 1'b1, 1'b1);
        send_word(32'h0BADF00D, 1'b1, 1'b1);
        idle(2);

        // Held output blocks the next completion beat
        b0.vec_ready = 1'b0;
        send_word(32'hA0B0C0D0, 1'b1, 1'b1);
        q0.push_back(32'h87654321);
        q1.push_back(32'h21436587);
        send_beat(8'h21, 1'b0);
        send_beat(8'h43, 1'b0);
        send_beat(8'h65, 1'b0);
        b0.axis_tvalid = 1'b1;
        b0.axis_tdata  = 8'h87;
        b0.axis_tlast  = 1'b1;
        @(negedge clk);
        check("stall_tready", {31'b0, b0.axis_tready}, 32'h0);
        check("stall_vec", b0.vec, 32'hA0B0C0D0);
        @(negedge clk);
        check("stall_tready2", {31'b0, b0.axis_tready}, 32'h0);
        @(posedge clk);
        #1;
        b0.vec_ready = 1'b1;
        @(negedge clk);
        check("unstall_tready", {31'b0, b0.axis_tready}, 32'h1);
        @(posedge clk);
        #1;
        b0.axis_tvalid = 1'b0;
        b0.axis_tlast  = 1'b0;
        @(negedge clk);
        check("reload_valid", {31'b0, b0.vec_valid}, 32'h1);
        @(posedge clk);
        #1;

        // 16-bit beats
        q2.push_back(32'h44332211);
        send_beat2(16'h2211, 1'b0);
        send_beat2(16'h4433, 1'b1);
        q2.push_back(32'hDDCCBBAA);
        send_beat2(16'hBBAA, 1'b0);
        send_beat2(16'hDDCC, 1'b1);
        idle(2);

`ifdef AXIS_TO_VECTOR_TLAST_CHECK_EN
        // Early tlast discards the partial word
        f0 = ferr_cnt;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        idle(3);
        check("early_ferr", ferr_cnt - f0, 32'd1);
        check("early_valid", {31'b0, b0.vec_valid}, 32'h0);
        ferr_exp += 1;
        send_word(32'h04030201, 1'b1, 1'b1);
        idle(2);

        // Missing tlast, then resync drops up to tlast
        f0 = ferr_cnt;
        send_word(32'hA4A3A2A1, 1'b0, 1'b0);
        send_beat(8'hEE, 1'b0);
        send_beat(8'hFF, 1'b1);
        idle(3);
        check("miss_ferr", ferr_cnt - f0, 32'd1);
        ferr_exp += 1;
        send_word(32'h04030201, 1'b1, 1'b1);
        idle(2);
`else
        // Count-only framing ignores tlast
        f0 = ferr_cnt;
        send_word(32'hA4A3A2A1, 1'b0, 1'b1);
        idle(3);
        check("count_ferr", ferr_cnt - f0, 32'd0);
        send_word(32'h04030201, 1'b1, 1'b1);
        idle(2);
`endif

        // Reset mid-word while a word is held
        b0.vec_ready = 1'b0;
        send_word(32'h55667788, 1'b1, 1'b0);
        @(negedge clk);
        check("held_vec", b0.vec, 32'h55667788);
        @(posedge clk);
        #1;
        send_beat(8'h99, 1'b0);
        send_beat(8'h98, 1'b0);
        sresetn = 1'b0;
        @(negedge clk);
        check("rst2_tready", {31'b0, b0.axis_tready}, 32'h0);
        @(posedge clk);
        #1;
        sresetn = 1'b1;
        @(negedge clk);
        check("rst2_vec", b0.vec, 32'h0);
        check("rst2_valid", {31'b0, b0.vec_valid}, 32'h0);
        check("rst2_ferr", {31'b0, b0.framing_err}, 32'h0);
        check("rst2_tready_hi", {31'b0, b0.axis_tready}, 32'h1);
        @(posedge clk);
        #1;
        b0.vec_ready = 1'b1;
        send_word(32'hCAFEF00D, 1'b1, 1'b1);
        idle(4);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        check("ferr_total", ferr_cnt, ferr_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
